// File: rtl/ws2812_frame_pkg.sv
// Shared types and timing constants for the WS2812 frame sequencer.
package ws2812_pkg;

    localparam int CLK_HZ   = 50_000_000;
    localparam int RESET_US = 300;
    // Latch gap in clock cycles, divided first so the product stays inside 32 bits.
    localparam int DEFAULT_RESET_CYCLES = (CLK_HZ / 1_000_000) * RESET_US;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        HOLD,
        WAIT_TX,
        GAP
    } frame_state_t;

endpackage

// File: rtl/ws2812_frame_scale.sv
// Combinational 3-channel brightness scaler: c' = (c * (level + 1)) >> 8.
module ws2812_scale
    import ws2812_pkg::*;
(
    input  grb_t       pix_in,
    input  logic [7:0] level_in,
    output grb_t       pix_out
);

    logic [23:0] flat_in;
    logic [23:0] flat_out;

    assign flat_in = pix_in;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [16:0] prod;
            assign prod = 17'(flat_in[gi*8 +: 8]) * (17'(level_in) + 17'd1);
            assign flat_out[gi*8 +: 8] = 8'(prod >> 8);
        end
    endgenerate

    assign pix_out = flat_out;

endmodule

// File: rtl/ws2812_frame.sv
// Frame sequencer feeding ws2812_oneled from a host-written GRB pixel buffer.
// Optional brightness scaling is enabled by defining WS2812_FRAME_BRIGHTNESS_EN.
module ws2812_frame
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
    parameter int IDX_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             wr_en_in,
    input  logic [IDX_W-1:0] wr_addr_in,
    input  logic [23:0]      wr_data_in,
    input  logic [7:0]       brightness_in,
    input  logic             oneled_ready_in,
    output logic [23:0]      grb_out,
    output logic             grb_out_valid,
    output logic             busy_out,
    output logic             frame_done_out
);

    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    frame_state_t     state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [CNT_W-1:0] gap_cnt_reg;
    logic             start_pending_reg;
    grb_t             buf_mem [NUM_LEDS];
    grb_t             load_word;

    // Buffer must clear on reset, so it lives in flops; out-of-range addresses match no entry.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_en_in && (32'(wr_addr_in) == i)) begin
                    buf_mem[i] <= wr_data_in;
                end
            end
        end
    end

`ifdef WS2812_FRAME_BRIGHTNESS_EN
    ws2812_scale u_scale (
        .pix_in   (buf_mem[idx_reg]),
        .level_in (brightness_in),
        .pix_out  (load_word)
    );
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness_in;
    assign load_word         = buf_mem[idx_reg];
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg         <= IDLE;
            idx_reg           <= '0;
            gap_cnt_reg       <= '0;
            start_pending_reg <= 1'b0;
            grb_out           <= '0;
            grb_out_valid     <= 1'b0;
            busy_out          <= 1'b0;
            frame_done_out    <= 1'b0;
        end else begin
            frame_done_out <= 1'b0;
            // Requests arriving mid-frame collapse into a single queued frame.
            if (start_in && (state_reg != IDLE)) begin
                start_pending_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (start_in || start_pending_reg) begin
                        start_pending_reg <= 1'b0;
                        idx_reg           <= '0;
                        busy_out          <= 1'b1;
                        state_reg         <= LOAD;
                    end
                end
                LOAD: begin
                    grb_out       <= load_word;
                    grb_out_valid <= 1'b1;
                    state_reg     <= SEND;
                end
                SEND: begin
                    if (grb_out_valid && oneled_ready_in) begin
                        grb_out_valid <= 1'b0;
                        if (32'(idx_reg) == NUM_LEDS - 1) begin
                            state_reg <= WAIT_TX;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    state_reg <= LOAD;
                end
                WAIT_TX: begin
                    if (oneled_ready_in) begin
                        gap_cnt_reg <= CNT_W'(RESET_CYCLES - 1);
                        state_reg   <= GAP;
                    end
                end
                GAP: begin
                    // Done fires on the edge where the count reaches zero.
                    if (gap_cnt_reg <= CNT_W'(1)) begin
                        gap_cnt_reg    <= '0;
                        frame_done_out <= 1'b1;
                        busy_out       <= 1'b0;
                        state_reg      <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame.sv
// Self-checking bench for ws2812_frame: directed vectors plus randomized traffic
// checked against a buffer-snapshot reference model.
module tb_ws2812_frame;

    localparam int N  = 6;
    localparam int RC = 20;
    localparam int IW = 3;

`ifdef WS2812_FRAME_BRIGHTNESS_EN
    localparam bit BRIGHT_EN = 1'b1;
`else
    localparam bit BRIGHT_EN = 1'b0;
`endif

    logic          clk_in          = 1'b0;
    logic          rst_n_in        = 1'b0;
    logic          start_in        = 1'b0;
    logic          wr_en_in        = 1'b0;
    logic [IW-1:0] wr_addr_in      = '0;
    logic [23:0]   wr_data_in      = '0;
    logic [7:0]    brightness_in   = 8'hFF;
    logic          oneled_ready_in = 1'b1;
    logic [23:0]   grb_out;
    logic          grb_out_valid;
    logic          busy_out;
    logic          frame_done_out;

    int vectors     = 0;
    int miscompares = 0;

    ws2812_frame #(
        .NUM_LEDS     (N),
        .RESET_CYCLES (RC)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .start_in        (start_in),
        .wr_en_in        (wr_en_in),
        .wr_addr_in      (wr_addr_in),
        .wr_data_in      (wr_data_in),
        .brightness_in   (brightness_in),
        .oneled_ready_in (oneled_ready_in),
        .grb_out         (grb_out),
        .grb_out_valid   (grb_out_valid),
        .busy_out        (busy_out),
        .frame_done_out  (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a word equals f(buffer contents as they stood in the cycle it was loaded).
    function automatic logic [23:0] scaled(input logic [23:0] w, input logic [7:0] b);
        int s;
        logic [23:0] r;
        s = int'(b) + 1;
        r = {8'((int'(w[23:16]) * s) / 256), 8'((int'(w[15:8]) * s) / 256), 8'((int'(w[7:0]) * s) / 256)};
        return BRIGHT_EN ? r : w;
    endfunction

    logic [23:0] mdl_buf  [N] = '{default: '0};
    logic [23:0] mdl_prev [N] = '{default: '0};
    logic [7:0]  brt_prev     = 8'hFF;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            foreach (mdl_buf[i]) begin
                mdl_buf[i]  = '0;
                mdl_prev[i] = '0;
            end
        end else begin
            mdl_prev = mdl_buf;
            brt_prev = brightness_in;
            if (wr_en_in && int'(wr_addr_in) < N) mdl_buf[int'(wr_addr_in)] = wr_data_in;
        end
    end

    // Ready driver: 0 always high, 1 low for one cycle after each accept, 2 random, 3 low.
    int   rdy_mode = 0;
    logic rdy_acc;
    always @(posedge clk_in) begin
        rdy_acc = grb_out_valid && oneled_ready_in;
        #1;
        case (rdy_mode)
            0:       oneled_ready_in = 1'b1;
            1:       oneled_ready_in = !rdy_acc;
            2:       oneled_ready_in = 1'($urandom_range(0, 1));
            default: oneled_ready_in = 1'b0;
        endcase
    end

    // Monitor / scoreboard
    logic [23:0] got_q[$];
    int          word_cnt     = 0;
    int          ret_cyc      = -1;
    int          frames_done  = 0;
    logic        prev_pending = 1'b0;
    logic        prev_valid   = 1'b0;
    logic        prev_busy    = 1'b0;
    logic        prev_done    = 1'b0;
    logic [23:0] prev_word    = '0;

    always @(negedge clk_in) begin
        logic xfer;
        if (!rst_n_in) begin
            word_cnt     = 0;
            ret_cyc      = -1;
            prev_pending = 1'b0;
            prev_valid   = 1'b0;
            prev_busy    = 1'b0;
            prev_done    = 1'b0;
        end else begin
            xfer = grb_out_valid && oneled_ready_in;
            if (prev_pending) begin
                check("valid_held", 32'(grb_out_valid), 32'd1);
                check("word_held", 32'(grb_out), 32'(prev_word));
            end
            if (grb_out_valid && !prev_valid)
                check("word_value", 32'(grb_out),
                      32'((word_cnt < N) ? scaled(mdl_prev[word_cnt], brt_prev) : 24'hxxxxxx));
            if (xfer) begin
                $display("xfer cycle %0d word %0d grb %06h", cyc, word_cnt, grb_out);
                got_q.push_back(grb_out);
                word_cnt++;
            end
            if (word_cnt == N && ret_cyc < 0 && oneled_ready_in && !xfer) ret_cyc = cyc;
            if (prev_done) check("done_single_pulse", 32'(frame_done_out), 32'd0);
            if (frame_done_out) begin
                $display("frame_done cycle %0d words %0d", cyc, word_cnt);
                check("words_per_frame", 32'(word_cnt), 32'(N));
                check("gap_len", 32'(cyc - ret_cyc), 32'(RC));
                check("busy_low_at_done", 32'(busy_out), 32'd0);
                check("busy_high_before_done", 32'(prev_busy), 32'd1);
                word_cnt = 0;
                ret_cyc  = -1;
                frames_done++;
            end
            prev_pending = grb_out_valid && !oneled_ready_in;
            prev_valid   = grb_out_valid;
            prev_word    = grb_out;
            prev_busy    = busy_out;
            prev_done    = frame_done_out;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input int a, input logic [23:0] d);
        wr_en_in   = 1'b1;
        wr_addr_in = IW'(a);
        wr_data_in = d;
        tick(1);
        wr_en_in   = 1'b0;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        tick(1);
        start_in = 1'b0;
    endtask

    // Returns at the falling edge inside the frame_done_out cycle.
    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!frame_done_out && n < budget);
        if (!frame_done_out) check("done_timeout", 32'(frame_done_out), 32'd1);
    endtask

    task automatic wait_words(input int k, input int budget);
        int n = 0;
        while (got_q.size() < k && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        if (got_q.size() < k) check("words_timeout", 32'(got_q.size()), 32'(k));
    endtask

    typedef struct {
        int          addr;
        logic [23:0] data;
        bit          accept;
    } wr_vec_t;

    typedef struct {
        logic [7:0]  level;
        logic [23:0] exp;
    } br_vec_t;

    wr_vec_t     wr_tbl [8];
    logic [23:0] exp_frame [N];
    br_vec_t     br_tbl [3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int seen;

        wr_tbl[0] = '{0, 24'h010000, 1'b1};
        wr_tbl[1] = '{1, 24'h020000, 1'b1};
        wr_tbl[2] = '{2, 24'h030000, 1'b1};
        wr_tbl[3] = '{6, 24'hDEAD01, 1'b0};
        wr_tbl[4] = '{3, 24'h040000, 1'b1};
        wr_tbl[5] = '{4, 24'h050000, 1'b1};
        wr_tbl[6] = '{7, 24'hBEEF02, 1'b0};
        wr_tbl[7] = '{5, 24'h060000, 1'b1};
        br_tbl[0] = '{8'h7F, 24'h7F4020};
        br_tbl[1] = '{8'hFF, 24'hFF8040};
        br_tbl[2] = '{8'h00, 24'h000000};

        // Reset state
        tick(3);
        check("rst_grb_out", 32'(grb_out), 32'd0);
        check("rst_valid", 32'(grb_out_valid), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_done", 32'(frame_done_out), 32'd0);
        rst_n_in = 1'b1;
        tick(2);

        // Basic frame from the write table; out-of-range addresses must not land anywhere
        foreach (exp_frame[i]) exp_frame[i] = '0;
        for (int i = 0; i < 8; i++) begin
            wr(wr_tbl[i].addr, wr_tbl[i].data);
            if (wr_tbl[i].accept) exp_frame[wr_tbl[i].addr] = wr_tbl[i].data;
        end
        rdy_mode = 1;
        base = got_q.size();
        pulse_start();
        @(negedge clk_in);
        check("lat_n1_valid", 32'(grb_out_valid), 32'd0);
        check("lat_n1_busy", 32'(busy_out), 32'd1);
        @(negedge clk_in);
        check("lat_n2_valid", 32'(grb_out_valid), 32'd1);
        wait_done(500);
        for (int i = 0; i < N; i++)
            check($sformatf("basic_word%0d", i), 32'(got_q[base + i]), 32'(exp_frame[i]));
        tick(2);

        // Backpressure: valid and data must hold for 50 cycles without advancing
        rdy_mode = 3;
        base = got_q.size();
        pulse_start();
        tick(2);
        check("bp_valid_up", 32'(grb_out_valid), 32'd1);
        tick(50);
        check("bp_no_accept", 32'(got_q.size()), 32'(base));
        check("bp_word0", 32'(grb_out), 32'(exp_frame[0]));
        rdy_mode = 1;
        wait_done(500);
        check("bp_first_word", 32'(got_q[base]), 32'(exp_frame[0]));
        tick(2);

        // Start while busy: two requests collapse into one extra frame
        seen = frames_done;
        pulse_start();
        tick(5);
        pulse_start();
        tick(3);
        pulse_start();
        wait_done(500);
        @(negedge clk_in);
        check("pend_d1_valid", 32'(grb_out_valid), 32'd0);
        check("pend_d1_busy", 32'(busy_out), 32'd1);
        @(negedge clk_in);
        check("pend_d2_valid", 32'(grb_out_valid), 32'd1);
        wait_done(500);
        tick(3 * RC);
        check("pend_frame_count", 32'(frames_done - seen), 32'd2);
        check("pend_idle", 32'(busy_out), 32'd0);

        // Writes during a frame: unloaded index goes out now, loaded index next frame
        rdy_mode = 1;
        base = got_q.size();
        pulse_start();
        wait_words(base + 2, 200);
        tick(1);
        wr(0, 24'h0A0B0C);
        wr(5, 24'hABCDEF);
        wait_done(500);
        check("wdf_word5_new", 32'(got_q[base + 5]), 32'h00ABCDEF);
        check("wdf_word0_old", 32'(got_q[base]), 32'(exp_frame[0]));
        tick(2);
        base = got_q.size();
        pulse_start();
        wait_done(500);
        check("wdf_next_word0", 32'(got_q[base]), 32'h000A0B0C);
        tick(2);

        // Reset mid-frame: asynchronous clear, no done, buffer empty afterwards
        base = got_q.size();
        pulse_start();
        wait_words(base + 4, 200);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("mid_rst_grb", 32'(grb_out), 32'd0);
        check("mid_rst_valid", 32'(grb_out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy_out), 32'd0);
        check("mid_rst_done", 32'(frame_done_out), 32'd0);
        tick(3);
        rst_n_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 3 * RC; i++) begin
            @(negedge clk_in);
            if (frame_done_out) seen++;
        end
        check("mid_rst_no_done", 32'(seen), 32'd0);
        tick(1);
        rdy_mode = 0;
        base = got_q.size();
        pulse_start();
        wait_done(500);
        for (int i = 0; i < N; i++)
            check($sformatf("cleared_word%0d", i), 32'(got_q[base + i]), 32'd0);
        tick(2);

        // Brightness scaling constants (only meaningful with the feature built in)
        if (BRIGHT_EN) begin
            wr(0, 24'hFF8040);
            for (int i = 0; i < 3; i++) begin
                brightness_in = br_tbl[i].level;
                base = got_q.size();
                pulse_start();
                wait_done(500);
                check($sformatf("bright_%02h", br_tbl[i].level), 32'(got_q[base]), 32'(br_tbl[i].exp));
                tick(2);
            end
        end

        // Randomized traffic checked by the reference model in the monitor
        rdy_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            wr_en_in      = ($urandom_range(0, 3) == 0);
            wr_addr_in    = IW'($urandom_range(0, 7));
            wr_data_in    = 24'($urandom);
            brightness_in = 8'($urandom);
            start_in      = (c == 0) || ($urandom_range(0, 60) == 0);
            tick(1);
        end
        wr_en_in = 1'b0;
        start_in = 1'b0;
        rdy_mode = 0;
        begin
            int quiet = 0;
            int n     = 0;
            while (quiet < 4 && n < 2000) begin
                @(negedge clk_in);
                n++;
                quiet = busy_out ? 0 : quiet + 1;
            end
        end
        check("random_drain_idle", 32'(busy_out), 32'd0);
        check("random_frame_boundary", 32'(word_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
